// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue controller: opcodes, flag/enable bit
// positions, response error bits and the sequencer state encoding.
package fpu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MUL = 3'd1;
  localparam logic [2:0] OP_DIV = 3'd2;
  localparam logic [2:0] OP_SQR = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;

  // Bit positions inside rsp_flags / fflags: {inv,div_zero,ov,un,inexact}
  localparam int FL_INX = 0;
  localparam int FL_UN  = 1;
  localparam int FL_OV  = 2;
  localparam int FL_DZ  = 3;
  localparam int FL_INV = 4;

  // Bit positions inside the one-hot unit enable vector
  localparam int EN_ADD = 0;
  localparam int EN_MUL = 1;
  localparam int EN_DIV = 2;
  localparam int EN_SQR = 3;
  localparam int EN_CMP = 4;

  localparam int ERR_ILL = 0;
  localparam int ERR_TMO = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/fpu_op_decode.sv
// Maps a command opcode to the one-hot fpu unit enable and flags
// opcodes that have no unit behind them.
module fpu_op_decode
  import fpu_pkg::*;
(
  input  logic [2:0] i_op,
  output logic [4:0] o_en,
  output logic       o_illegal
);

  always_comb begin
    o_en      = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_ADD:  o_en[EN_ADD] = 1'b1;
      OP_MUL:  o_en[EN_MUL] = 1'b1;
      OP_DIV:  o_en[EN_DIV] = 1'b1;
      OP_SQR:  o_en[EN_SQR] = 1'b1;
      OP_CMP:  o_en[EN_CMP] = 1'b1;
      default: o_illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding command sequencer in front of the fpu top: loads the
// operands, pulses the unit reset, waits for a qualified done and returns a response.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned MIN_CYC = 2,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned RST_CYC = 1
) (
  input  logic        clk,
  input  logic        rstp,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [2:0]  cmd_rm,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_flags,
  output logic [1:0]  rsp_err,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        busy,
  output logic [31:0] fpu_in1p,
  output logic [31:0] fpu_in2p,
  output logic [2:0]  fpu_opcode,
  output logic [2:0]  fpu_round_mp,
  output logic        fpu_rstp,
  output logic        fpu_act,
  output logic        fpu_enable_add,
  output logic        fpu_enable_mul,
  output logic        fpu_enable_div,
  output logic        fpu_enable_sqr,
  output logic        fpu_enable_comp,
  input  logic [31:0] fpu_out,
  input  logic        fpu_ov,
  input  logic        fpu_un,
  input  logic        fpu_inv,
  input  logic        fpu_inexact,
  input  logic        fpu_div_zero,
  input  logic        fpu_less,
  input  logic        fpu_eq,
  input  logic        fpu_great,
  input  logic        fpu_done,
  output logic [1:0]  o_dbg_state
);

  localparam int CW = 16;
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_CYC);
  localparam logic [CW-1:0] TO_C     = CW'(TIMEOUT);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);

  state_t        r_state;
  logic [2:0]    r_op, r_rm;
  logic [31:0]   r_a, r_b;
  logic [4:0]    r_en;
  logic [CW-1:0] r_cnt, r_rcnt;
  logic [31:0]   r_rsp_data;
  logic [4:0]    r_rsp_flags, r_fflags;
  logic [1:0]    r_rsp_err;

  logic [4:0]  w_dec_en, w_flags, w_en_out;
  logic        w_illegal, w_accept, w_qual, w_is_cmp;
  logic [31:0] w_result;

  fpu_op_decode u_dec (
    .i_op      (cmd_op),
    .o_en      (w_dec_en),
    .o_illegal (w_illegal)
  );

  assign w_accept = cmd_valid && cmd_ready;
  // A done seen before MIN_CYC RUN cycles may belong to the previous op.
  assign w_qual   = (r_state == ST_RUN) && fpu_done && (r_cnt >= MIN_C);
  assign w_is_cmp = (r_op == OP_CMP);
  assign w_result = w_is_cmp ? {29'b0, fpu_less, fpu_eq, fpu_great} : fpu_out;

  always_comb begin
    w_flags         = '0;
    w_flags[FL_INV] = fpu_inv;
    if (!w_is_cmp) begin
      w_flags[FL_DZ]  = fpu_div_zero;
      w_flags[FL_OV]  = fpu_ov;
      w_flags[FL_UN]  = fpu_un;
      w_flags[FL_INX] = fpu_inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_rm        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_en        <= '0;
      r_cnt       <= '0;
      r_rcnt      <= '0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_rsp_err   <= '0;
      r_fflags    <= '0;
    end else begin
      // Clear takes effect before the capturing op's flags are merged in.
      r_fflags <= (fflags_clr ? 5'b0 : r_fflags) | (w_qual ? w_flags : 5'b0);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_rsp_data         <= '0;
              r_rsp_flags        <= '0;
              r_rsp_err          <= '0;
              r_rsp_err[ERR_ILL] <= 1'b1;
              r_en               <= '0;
              r_state            <= ST_RESP;
            end else begin
              r_op    <= cmd_op;
              r_a     <= cmd_a;
              r_b     <= (cmd_op == OP_SQR) ? 32'b0 : cmd_b;
              r_rm    <= cmd_rm;
              r_en    <= w_dec_en;
              r_rcnt  <= '0;
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (r_rcnt == RST_LAST) begin
            r_cnt   <= CW'(1);
            r_state <= ST_RUN;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (w_qual) begin
            r_rsp_data  <= w_result;
            r_rsp_flags <= w_flags;
            r_rsp_err   <= '0;
            r_state     <= ST_RESP;
          end else if (r_cnt == TO_C) begin
            r_rsp_data         <= '0;
            r_rsp_flags        <= '0;
            r_rsp_err          <= '0;
            r_rsp_err[ERR_TMO] <= 1'b1;
            r_state            <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_en_out        = (r_state == ST_IDLE) ? 5'b0 : r_en;
  assign cmd_ready       = !rstp && (r_state == ST_IDLE);
  assign rsp_valid       = (r_state == ST_RESP);
  assign rsp_data        = r_rsp_data;
  assign rsp_flags       = r_rsp_flags;
  assign rsp_err         = r_rsp_err;
  assign fflags          = r_fflags;
  assign busy            = (r_state != ST_IDLE);
  assign fpu_in1p        = r_a;
  assign fpu_in2p        = r_b;
  assign fpu_opcode      = r_op;
  assign fpu_round_mp    = r_rm;
  assign fpu_rstp        = rstp || (r_state == ST_LOAD);
  assign fpu_act         = (r_state == ST_RUN);
  assign fpu_enable_add  = w_en_out[EN_ADD];
  assign fpu_enable_mul  = w_en_out[EN_MUL];
  assign fpu_enable_div  = w_en_out[EN_DIV];
  assign fpu_enable_sqr  = w_en_out[EN_SQR];
  assign fpu_enable_comp = w_en_out[EN_CMP];
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed table-driven bench for fpu_issue_ctrl with a scripted fpu stub
// that raises done on a chosen RUN cycle.
module tb_fpu_issue_ctrl;

  localparam int MIN_CYC = 2;
  localparam int TIMEOUT = 64;
  localparam int RST_CYC = 1;

  logic        clk = 1'b0;
  logic        rstp;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op, cmd_rm;
  logic [31:0] cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_flags, fflags;
  logic [1:0]  rsp_err;
  logic        fflags_clr, busy;
  logic [31:0] fpu_in1p, fpu_in2p, fpu_out;
  logic [2:0]  fpu_opcode, fpu_round_mp;
  logic        fpu_rstp, fpu_act;
  logic        fpu_enable_add, fpu_enable_mul, fpu_enable_div, fpu_enable_sqr, fpu_enable_comp;
  logic        fpu_ov, fpu_un, fpu_inv, fpu_inexact, fpu_div_zero;
  logic        fpu_less, fpu_eq, fpu_great, fpu_done;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.MIN_CYC(MIN_CYC), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .rstp(rstp), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_rm(cmd_rm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .fflags(fflags), .fflags_clr(fflags_clr),
    .busy(busy), .fpu_in1p(fpu_in1p), .fpu_in2p(fpu_in2p), .fpu_opcode(fpu_opcode),
    .fpu_round_mp(fpu_round_mp), .fpu_rstp(fpu_rstp), .fpu_act(fpu_act),
    .fpu_enable_add(fpu_enable_add), .fpu_enable_mul(fpu_enable_mul),
    .fpu_enable_div(fpu_enable_div), .fpu_enable_sqr(fpu_enable_sqr),
    .fpu_enable_comp(fpu_enable_comp), .fpu_out(fpu_out), .fpu_ov(fpu_ov),
    .fpu_un(fpu_un), .fpu_inv(fpu_inv), .fpu_inexact(fpu_inexact),
    .fpu_div_zero(fpu_div_zero), .fpu_less(fpu_less), .fpu_eq(fpu_eq),
    .fpu_great(fpu_great), .fpu_done(fpu_done), .o_dbg_state(dbg_state)
  );

  // fl = {inv,div_zero,ov,un,inexact} driven by the stub; cmp = {less,eq,great};
  // done_at = RUN cycle on which the stub raises done (0 = never)
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] out;
    logic [4:0]  fl;
    logic [2:0]  cmp;
    int          done_at;
    logic [31:0] exp_data;
    logic [4:0]  exp_flags;
    logic [1:0]  exp_err;
    logic [4:0]  exp_en;
    int          exp_run;
  } vec_t;

  vec_t       vecs[9];
  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_ff = 5'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v, input int clr_at, input int hold, input string tag);
    int run_c, rst_c, guard;
    logic [31:0] exp_in2;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_rm = v.rm;
    fpu_out = v.out;
    {fpu_inv, fpu_div_zero, fpu_ov, fpu_un, fpu_inexact} = v.fl;
    {fpu_less, fpu_eq, fpu_great} = v.cmp;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check({tag, "_accept_wait"}, 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    run_c = 0; rst_c = 0; guard = 0;
    while (!rsp_valid && guard < 300) begin
      if (fpu_rstp) rst_c++;
      if (fpu_act) begin
        run_c++;
        fpu_done   = (v.done_at != 0) && (run_c >= v.done_at);
        fflags_clr = (run_c == clr_at);
      end else begin
        fpu_done   = 1'b0;
        fflags_clr = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    fpu_done = 1'b0; fflags_clr = 1'b0;
    if (guard >= 300) check({tag, "_rsp_wait"}, 64'(rsp_valid), 64'd1);
    if (v.exp_err == 2'b00) exp_ff = (clr_at > 0) ? v.exp_flags : (exp_ff | v.exp_flags);
    check({tag, "_data"},  64'(rsp_data),  64'(v.exp_data));
    check({tag, "_flags"}, 64'(rsp_flags), 64'(v.exp_flags));
    check({tag, "_err"},   64'(rsp_err),   64'(v.exp_err));
    check({tag, "_fflags"}, 64'(fflags),   64'(exp_ff));
    check({tag, "_run_cycles"}, 64'(run_c), 64'(v.exp_run));
    check({tag, "_rst_cycles"}, 64'(rst_c), 64'(v.exp_err[0] ? 0 : RST_CYC));
    check({tag, "_enables"},
          64'({fpu_enable_comp, fpu_enable_sqr, fpu_enable_div, fpu_enable_mul, fpu_enable_add}),
          64'(v.exp_en));
    check({tag, "_ready_busy"}, 64'({cmd_ready, busy}), 64'(2'b01));
    if (!v.exp_err[0]) begin
      exp_in2 = (v.op == 3'd3) ? 32'h0 : v.b;
      check({tag, "_fpu_ops"}, {fpu_in1p, fpu_in2p}, {v.a, exp_in2});
      check({tag, "_fpu_opc_rm"}, 64'({fpu_opcode, fpu_round_mp}), 64'({v.op, v.rm}));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_stable"},
            64'({rsp_valid, cmd_ready, rsp_data, rsp_flags, rsp_err}),
            64'({1'b1, 1'b0, v.exp_data, v.exp_flags, v.exp_err}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_back_idle"}, 64'({busy, rsp_valid, cmd_ready}), 64'(3'b001));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    vec_t v;
    rstp = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_rm = '0;
    rsp_ready = 1'b0; fflags_clr = 1'b0; fpu_out = '0; fpu_done = 1'b0;
    {fpu_ov, fpu_un, fpu_inv, fpu_inexact, fpu_div_zero, fpu_less, fpu_eq, fpu_great} = '0;

    //           op    a             b             rm    out           fl        cmp     done data          flags     err    en        run
    vecs[0] = '{3'd0, 32'h3F800000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000, 3'b000, 2, 32'h40400000, 5'b00000, 2'b00, 5'b00001, 2};
    vecs[1] = '{3'd1, 32'h40000000, 32'h40400000, 3'd1, 32'h40C00000, 5'b00000, 3'b010, 3, 32'h40C00000, 5'b00000, 2'b00, 5'b00010, 3};
    vecs[2] = '{3'd2, 32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'b01000, 3'b000, 4, 32'h7F800000, 5'b01000, 2'b00, 5'b00100, 4};
    vecs[3] = '{3'd3, 32'h40000000, 32'h12345678, 3'd2, 32'h3FB504F3, 5'b00001, 3'b000, 2, 32'h3FB504F3, 5'b00001, 2'b00, 5'b01000, 2};
    vecs[4] = '{3'd4, 32'h40000000, 32'h3F800000, 3'd3, 32'hDEADBEEF, 5'b00100, 3'b001, 1, 32'h00000001, 5'b00000, 2'b00, 5'b10000, 2};
    vecs[5] = '{3'd4, 32'h7FC00000, 32'h3F800000, 3'd0, 32'h00000000, 5'b10001, 3'b100, 3, 32'h00000004, 5'b10000, 2'b00, 5'b10000, 3};
    vecs[6] = '{3'd6, 32'h3F800000, 32'h3F800000, 3'd0, 32'h11111111, 5'b11111, 3'b111, 1, 32'h00000000, 5'b00000, 2'b01, 5'b00000, 0};
    vecs[7] = '{3'd1, 32'h3F800000, 32'h3F800000, 3'd0, 32'h3F800000, 5'b00001, 3'b000, 0, 32'h00000000, 5'b00000, 2'b10, 5'b00010, TIMEOUT};
    vecs[8] = '{3'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 3'd0, 32'h7F800000, 5'b00101, 3'b000, 6, 32'h7F800000, 5'b00101, 2'b00, 5'b00001, 6};

    repeat (3) @(negedge clk);
    check("reset_ready_rst_valid", 64'({cmd_ready, fpu_rstp, rsp_valid, busy, fpu_act}), 64'(5'b01000));
    check("reset_rsp_regs", 64'({rsp_data, rsp_flags, rsp_err, fflags}), 64'(0));
    check("reset_enables",
          64'({fpu_enable_comp, fpu_enable_sqr, fpu_enable_div, fpu_enable_mul, fpu_enable_add}), 64'(0));
    rstp = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'({cmd_ready, fpu_rstp, fpu_act}), 64'(3'b100));

    for (int i = 0; i < 9; i++) run_cmd(vecs[i], 0, 0, $sformatf("vec%0d", i));

    // fflags_clr lands on the capture edge: only the new op's flags survive
    v = '{3'd1, 32'h3FC00000, 32'h3FC00000, 3'd0, 32'h40100000, 5'b00001, 3'b000, 3,
          32'h40100000, 5'b00001, 2'b00, 5'b00010, 3};
    run_cmd(v, 3, 0, "clr_on_capture");

    run_cmd(vecs[2], 0, 10, "backpressure");

    // Reset in the middle of RUN
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 32'h3F800000; cmd_b = 32'h3F800000; cmd_rm = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!fpu_act && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("midrun_reached_run", 64'(fpu_act), 64'd1);
    @(negedge clk);
    rstp = 1'b1;
    @(negedge clk);
    check("midrun_reset_state", 64'({busy, rsp_valid, fpu_act, cmd_ready, fpu_rstp}), 64'(5'b00001));
    check("midrun_reset_fflags", 64'(fflags), 64'(0));
    rstp = 1'b0;
    exp_ff = 5'b0;
    @(negedge clk);
    check("after_reset_idle", 64'({cmd_ready, fpu_rstp, busy, rsp_valid}), 64'(4'b1000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Command-side sequencer that drives the fpu top as its initiator. It accepts one FP command at a time over a valid/ready channel and programs the fpu opcode, operands, rounding mode, unit reset, act and enables. It waits for done, bounded by a minimum-latency qualifier and a timeout, then returns a registered response carrying the result, flags and compare bits. It also keeps sticky accrued exception flags for software.

Parameters:
MIN_CYC, 2, minimum RUN cycles before fpu_done is accepted; masks stale done left over from the previous operation
TIMEOUT, 64, RUN cycles without a qualified done before the command is aborted with a timeout error
RST_CYC, 1, cycles fpu_rstp is held high in LOAD (must be >=1)

Ports:
clk  in  1  clock
rstp  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_op  in  3  0 add, 1 mul, 2 div, 3 sqrt, 4 compare; 5-7 illegal
cmd_a, cmd_b  in  32  IEEE-754 single operands (cmd_b ignored for sqrt)
cmd_rm  in  3  rounding mode
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_data  out  32  fpu result; for compare {29'b0,less,eq,great}
rsp_flags  out  5  {inv,div_zero,ov,un,inexact} of this op
rsp_err  out  2  {timeout,illegal}
fflags  out  5  sticky OR of rsp_flags, same bit order
fflags_clr  in  1  clear fflags
busy  out  1  state != IDLE
fpu_in1p, fpu_in2p  out  32  fpu operands
fpu_opcode  out  3  fpu opcode
fpu_round_mp  out  3  fpu rounding mode
fpu_rstp  out  1  fpu unit reset
fpu_act  out  1  fpu activate
fpu_enable_add, fpu_enable_mul, fpu_enable_div, fpu_enable_sqr, fpu_enable_comp  out  1 each  one-hot unit enable
fpu_out  in  32  fpu result
fpu_ov, fpu_un, fpu_inv, fpu_inexact, fpu_div_zero, fpu_less, fpu_eq, fpu_great, fpu_done  in  1 each  fpu status

Behaviour:
- States: IDLE, LOAD, RUN, RESP.
- Reset (rstp=1): state IDLE. rsp_valid, rsp_data, rsp_flags, rsp_err, fflags, counters, fpu_act and all enables are 0. fpu_rstp=1 during reset so the fpu units reset together with the controller. cmd_ready=0 while rstp=1. Reset mid-operation abandons the command with no response.
- IDLE: cmd_ready=1, fpu_act=0, fpu_rstp=0.
  - Legal op accepted: latch op/a/b/rm into the operand register, go to LOAD.
  - Illegal op accepted: go straight to RESP with rsp_err=2'b01, rsp_data=0, rsp_flags=0. No fpu activity; fflags unchanged.
- LOAD: fpu_rstp=1 for RST_CYC cycles, then go to RUN.
- RUN: fpu_act=1. Cycle counter starts at 1 on the first RUN cycle.
  - Qualified done: fpu_done=1 and cnt>=MIN_CYC.
  - On qualified done: capture fpu_out (or the compare bits for op 4) and the five flags into the rsp registers with rsp_err=0, and OR the flags into fflags in the same edge. Go to RESP.
  - cnt==TIMEOUT with no qualified done: rsp_data=0, rsp_flags=0, rsp_err=2'b10, fflags unchanged. Go to RESP.
- From LOAD through RESP: fpu_in1p/in2p/opcode/round_mp and the one-hot enable come from the latched registers and stay stable. For sqrt, fpu_in2p=0. In IDLE all enables are 0 and the fpu operand outputs hold their last values.
- RESP: rsp_valid=1, response fields stable. On rsp_ready go to IDLE. cmd_ready stays 0 in RESP, so there is no back-to-back overlap; minimum command-to-command spacing is 1+RST_CYC+MIN_CYC+1 cycles.
- Latency: accept edge to rsp_valid = 1 + RST_CYC + k cycles, where k>=MIN_CYC is the RUN cycle on which done qualifies.
- fflags_clr: clears fflags on the next edge. When it coincides with a capture, fflags = the new op's flags only (clear first, then set).
- Compare opcode: fpu_round_mp is still driven but ignored by the fpu. rsp_flags takes inv from fpu_inv; all other flag bits are 0.

Decomposition:
- Shared package fpu_pkg holds:
  - opcode constants OP_ADD=0, OP_MUL=1, OP_DIV=2, OP_SQR=3, OP_CMP=4
  - flag bit indices FL_INX=0, FL_UN=1, FL_OV=2, FL_DZ=3, FL_INV=4
  - state encoding
  - rsp_err bit positions
- One natural sub-module, fpu_op_decode: combinational op→one-hot enable plus an illegal flag. Everything else stays in the top FSM.

Test Plan:
- Add, MIN_CYC=2: a=0x3F800000 (1.0), b=0x40000000 (2.0), op 0, rm 0 → rsp_data=0x40400000, rsp_flags=0, rsp_err=0; fpu_rstp high exactly 1 cycle and enable_add the only enable.
- Divide by zero: a=0x3F800000, b=0x00000000, op 2 → rsp_data=0x7F800000, rsp_flags[3]=1, fflags=5'b01000; then fflags_clr on the same cycle as the next capture → fflags equals that op's flags only.
- Compare: a=0x40000000, b=0x3F800000, op 4 → rsp_data=0x00000001 (great). Stale fpu_done=1 held from the previous op on RUN cycle 1 is ignored; capture happens no earlier than RUN cycle MIN_CYC.
- Illegal and timeout: op 6 → response the cycle after accept with rsp_err=2'b01 and fpu_act never asserted. fpu model that never raises done → rsp_err=2'b10 exactly TIMEOUT RUN cycles after RUN entry.
- Backpressure and reset: hold rsp_ready=0 for 10 cycles → rsp fields stable and cmd_ready=0 throughout. Assert rstp mid-RUN → next cycle IDLE, rsp_valid=0, fflags=0, fpu_rstp=1 during reset.
